shift_compute_n: RTL and testbench

- Parametrised successor to the fixed 8-bit serial shift/compute tile.
- Serial data enters an operand shift register.
- A bit-serial ALU combines the operand with one of NREGS internal accumulator registers over WIDTH cycles and writes the result back to that register.
- Sits behind the tile's ui_in/uo_out pin mapping; the tile wrapper maps the ports onto pins.

---
 rtl/shift_compute_n.sv | 198 +++++++++++++++++++
 tb/tb_shift_compute_n.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_compute_n.sv
// ---------------------------------------------------------------------------
// shift_compute_n
//
// Serial shift/compute tile. Operand bits arrive serially and fill an operand
// shift register. A bit-serial ALU then combines that operand with one of NREGS
// accumulator registers, one bit per cycle over WIDTH cycles, starting with the
// LSB. The result is written back into the selected accumulator.
//
// Parameters:
//   WIDTH  operand and accumulator width. Must be 2 or more.
//   NREGS  number of accumulators. Must be a power of 2 and 2 or more.
//   SEL_W  width of select. It is derived from NREGS and must not be overridden.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous reset, active low
//   data_in    serial operand bit. It enters at the MSB end, so the operand
//              is sent LSB first.
//   shift_en   shifts data_in into the operand register while idle
//   select     index of the target accumulator, captured at start
//   op         operation, captured at start:
//              00 load, 01 add, 10 and, 11 xor (or sub)
//   start      starts an operation when idle. It is a level input.
//   busy       high while an operation is executing
//   done       one-cycle pulse on the cycle after the result is written
//   carry_out  final carry of the last add/sub. It is 0 after load/and/xor.
//   result     copy of the last value written to an accumulator
//   sout       current LSB of the operand register
//
// Optional feature macro: SHIFT_COMPUTE_SUB_EN
//   When it is defined, op 11 subtracts the operand from the accumulator.
//   The subtract is done as acc + ~operand + 1, and carry_out = 1 means
//   there was no borrow.
//   When it is undefined, op 11 is xor and no subtract logic is built.
// ---------------------------------------------------------------------------
module shift_compute_n #(
  parameter int WIDTH = 8,
  parameter int NREGS = 8,
  parameter int SEL_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             data_in,
  input  logic             shift_en,
  input  logic [SEL_W-1:0] select,
  input  logic [1:0]       op,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             carry_out,
  output logic [WIDTH-1:0] result,
  output logic             sout
);

  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_AND  = 2'b10;
  localparam logic [1:0] OP_X    = 2'b11;  // xor, or sub when enabled

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   operand_r;
  logic [WIDTH-1:0]   acc_r [NREGS];
  logic [SEL_W-1:0]   sel_r;
  logic [1:0]         op_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               carry_r;

  logic [WIDTH-1:0]   acc_sel_s;
  logic               f_s;
  logic               c_next_s;
  logic [WIDTH-1:0]   acc_next_s;
  logic               start_carry_s;

  // Result bit for one bit position
  function automatic logic alu_bit(input logic [1:0] fop, input logic a,
                                   input logic b, input logic c);
    logic r;
    case (fop)
      OP_LOAD: r = a;
      OP_ADD:  r = a ^ b ^ c;
      OP_AND:  r = a & b;
`ifdef SHIFT_COMPUTE_SUB_EN
      OP_X:    r = (~a) ^ b ^ c;   // b + ~a + c
`else
      OP_X:    r = a ^ b;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Carry into the next bit position. It is always 0 for the logical ops.
  function automatic logic alu_carry(input logic [1:0] fop, input logic a,
                                     input logic b, input logic c);
    logic r;
    case (fop)
      OP_ADD:  r = (a & b) | (c & (a ^ b));
`ifdef SHIFT_COMPUTE_SUB_EN
      OP_X:    r = ((~a) & b) | (c & ((~a) ^ b));
`else
      OP_X:    r = 1'b0;
`endif
      OP_LOAD: r = 1'b0;
      OP_AND:  r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  assign acc_sel_s = acc_r[sel_r];
  assign sout      = operand_r[0];

  // Serial ALU datapath: new bit, next carry and the rotated accumulator value
  always_comb begin
    f_s        = alu_bit(op_r, operand_r[0], acc_sel_s[0], carry_r);
    c_next_s   = alu_carry(op_r, operand_r[0], acc_sel_s[0], carry_r);
    acc_next_s = {f_s, acc_sel_s[WIDTH-1:1]};
  end

  // Initial carry: 1 for subtract (the +1 of two's complement), otherwise 0
  always_comb begin
`ifdef SHIFT_COMPUTE_SUB_EN
    if (op == OP_X) begin
      start_carry_s = 1'b1;
    end else begin
      start_carry_s = 1'b0;
    end
`else
    start_carry_s = 1'b0;
`endif
  end

  // Control FSM, operand and accumulator registers, and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      operand_r <= '0;
      for (int i = 0; i < NREGS; i++) begin
        acc_r[i] <= '0;
      end
      sel_r     <= '0;
      op_r      <= 2'b00;
      cnt_r     <= '0;
      carry_r   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      carry_out <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          // start has priority over shift_en. A shift does not happen in
          // the same cycle as a start.
          if (start) begin
            sel_r   <= select;
            op_r    <= op;
            cnt_r   <= '0;
            carry_r <= start_carry_s;
            busy    <= 1'b1;
            state_r <= EXEC;
          end else if (shift_en) begin
            operand_r <= {data_in, operand_r[WIDTH-1:1]};
          end
        end
        EXEC: begin
          // The operand rotates, so it is back to its original value
          // after WIDTH cycles.
          operand_r    <= {operand_r[0], operand_r[WIDTH-1:1]};
          acc_r[sel_r] <= acc_next_s;
          carry_r      <= c_next_s;
          if (cnt_r == LAST_BIT) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            result    <= acc_next_s;
            carry_out <= c_next_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_compute_n.sv
// ---------------------------------------------------------------------------
// tb_shift_compute_n
//
// Self-checking bench for shift_compute_n with WIDTH=8 and NREGS=8.
// The stimulus side pushes the expected {carry, result} pair into a queue
// each time it issues an operation. A separate monitor pops an entry on every
// done pulse and compares it with the DUT outputs. The reference model keeps
// the accumulators and the operand as plain integers and uses ordinary
// arithmetic.
// ---------------------------------------------------------------------------
module tb_shift_compute_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_in = 1'b0;
  logic       shift_en = 1'b0;
  logic [2:0] select = 3'd0;
  logic [1:0] op = 2'b00;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       carry_out;
  logic [7:0] result;
  logic       sout;

  int cmp_count = 0;
  int err_count = 0;

  logic [8:0] exp_q[$];
  int         m_acc[8];
  int         m_operand = 0;

  shift_compute_n #(.WIDTH(8), .NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .shift_en(shift_en),
    .select(select), .op(op), .start(start), .busy(busy), .done(done),
    .carry_out(carry_out), .result(result), .sout(sout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: apply one operation and return {carry, result}
  function automatic logic [8:0] model_exec(input logic [1:0] o, input int s);
    int a, b, r;
    logic c;
    a = m_operand;
    b = m_acc[s];
    c = 1'b0;
    case (o)
      2'b00: r = a;
      2'b01: begin r = a + b; c = (r > 255); end
      2'b10: r = a & b;
`ifdef SHIFT_COMPUTE_SUB_EN
      2'b11: begin r = b - a; c = (b >= a); end
`else
      2'b11: r = a ^ b;
`endif
      default: r = 0;
    endcase
    r = r & 255;
    m_acc[s] = r;
    return {c, 8'(r)};
  endfunction

  // Monitor: every done pulse consumes one expected entry
  always @(posedge clk) begin
    logic [8:0] e;
    #1;
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        cmp_count++;
        err_count++;
        $display("FAIL done_unexpected: got done=1 expected no pending op at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e[7:0]));
        check("carry_out", 32'(carry_out), 32'(e[8]));
      end
    end
  end

  task automatic shift_in(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
      shift_en = 1'b1;
      data_in = v[i];
    end
    @(negedge clk);
    shift_en = 1'b0;
    m_operand = v;
  endtask

  // mode 0: plain op; 1: start/shift pulses during EXEC; 2: reset at EXEC cycle 4
  task automatic run_op(input logic [1:0] o, input logic [2:0] s, input int mode);
    logic [7:0] opv;
    int k;
    bit seen;
    opv = 8'(m_operand);
    @(negedge clk);
    start = 1'b1;
    shift_en = 1'b0;
    op = o;
    select = s;
    if (mode != 2) exp_q.push_back(model_exec(o, int'(s)));
    seen = 1'b0;
    k = 0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      shift_en = 1'b0;
      if (mode == 1 && (k == 3 || k == 5)) begin
        start = 1'b1;
        shift_en = 1'b1;
        data_in = 1'($urandom);
        op = 2'($urandom);
        select = 3'($urandom);
      end
      if (mode == 2 && k == 4) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_sout", 32'(sout), 32'd0);
        for (int i = 0; i < 8; i++) m_acc[i] = 0;
        m_operand = 0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k <= 8) check("sout_replay", 32'(sout), 32'(opv[k-1]));
      if (k == 1) check("busy_exec", 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
        check("latency", 32'(k), 32'd9);
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_b2b(input logic [1:0] o1, input logic [2:0] s1,
                         input logic [1:0] o2, input logic [2:0] s2);
    int k;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    op = o1;
    select = s1;
    exp_q.push_back(model_exec(o1, int'(s1)));
    k = 0;
    seen = 1'b0;
    while (k < 20 && !seen) begin
      @(negedge clk);
      k++;
      if (done) begin
        seen = 1'b1;
        check("b2b_lat1", 32'(k), 32'd9);
        check("b2b_busy_gap", 32'(busy), 32'd0);
        op = o2;
        select = s2;
        exp_q.push_back(model_exec(o2, int'(s2)));
      end
    end
    if (!seen) check("b2b_timeout1", 32'd0, 32'd1);
    @(negedge clk);
    k++;
    start = 1'b0;
    check("b2b_busy_again", 32'(busy), 32'd1);
    seen = 1'b0;
    while (k < 40 && !seen) begin
      @(negedge clk);
      k++;
      if (done) begin
        seen = 1'b1;
        check("b2b_lat2", 32'(k), 32'd18);
      end
    end
    if (!seen) check("b2b_timeout2", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected normal end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] v;
    logic [1:0] o;
    logic [2:0] s;
    for (int i = 0; i < 8; i++) m_acc[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_sout", 32'(sout), 32'd0);
    rst_n = 1'b1;

    // Directed cases
    shift_in(8'h35); run_op(2'b00, 3'd2, 0);
    shift_in(8'h0F); run_op(2'b01, 3'd2, 0);
    shift_in(8'hFF); run_op(2'b00, 3'd5, 0);
    shift_in(8'h01); run_op(2'b01, 3'd5, 0);
    shift_in(8'hF0); run_op(2'b00, 3'd3, 0);
    shift_in(8'h3C); run_op(2'b10, 3'd3, 0);
    shift_in(8'hF0); run_op(2'b00, 3'd4, 0);
    shift_in(8'h3C); run_op(2'b11, 3'd4, 0);
    shift_in(8'h10); run_op(2'b00, 3'd1, 0);
    shift_in(8'h01); run_op(2'b11, 3'd1, 0);
    shift_in(8'h00); run_op(2'b00, 3'd1, 0);
    shift_in(8'h01); run_op(2'b11, 3'd1, 0);

    // Start and shift pulses while busy are ignored, and the operand survives
    shift_in(8'hA7); run_op(2'b01, 3'd6, 1);
    run_op(2'b00, 3'd7, 0);

    // Back-to-back operations with start held high
    shift_in(8'h5A); run_b2b(2'b00, 3'd0, 2'b01, 3'd0);

    // Reset in the middle of EXEC, then an add of operand 0 reads back the cleared register
    shift_in(8'hC3); run_op(2'b00, 3'd2, 0);
    run_op(2'b01, 3'd2, 2);
    run_op(2'b01, 3'd2, 0);

    // Random operations
    for (int n = 0; n < 30; n++) begin
      v = 8'($urandom);
      o = 2'($urandom);
      s = 3'($urandom);
      if (($urandom % 4) != 0) shift_in(v);
      run_op(o, s, 0);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
    $finish;
  end

endmodule
